// File: rtl/horizontal_tf_gen_if.sv
// horizontal_tf_gen_if: request, configuration and twiddle-output bundle between
// the stage controller (master) and horizontal_tf_gen (slave).
interface horizontal_tf_gen_if #(
    parameter int P_WIDTH = 64,
    parameter int NCH     = 4,
    parameter int CNT_W   = 4
);
    logic                   start;
    logic                   cen;
    logic                   busy;
    logic                   tf_valid;
    logic                   done;
    logic [CNT_W-1:0]       len_in;
    logic [CNT_W-1:0]       tf_idx;
    logic [P_WIDTH-1:0]     N_in;
    logic [P_WIDTH-1:0]     step_in;
    logic [P_WIDTH-1:0]     stride_in;
    logic [NCH*P_WIDTH-1:0] base_in;
    logic [NCH*P_WIDTH-1:0] tf_out;
    modport master (
        output start, len_in, N_in, step_in, stride_in, base_in, cen,
        input  busy, tf_valid, tf_out, tf_idx, done
    );
    modport slave (
        input  start, len_in, N_in, step_in, stride_in, base_in, cen,
        output busy, tf_valid, tf_out, tf_idx, done
    );
endinterface

// File: rtl/horizontal_tf_gen.sv
// horizontal_tf_gen: NCH lanes of base[c]*step^k mod N, one term per unstalled cycle.
// Define HTF_LANE_STRIDE_EN to derive lanes 1..NCH-1 from lane 0 as base0*stride^c in an INIT phase.
module horizontal_tf_gen #(
    parameter int P_WIDTH = 64,
    parameter int NCH     = 4,
    parameter int CNT_W   = 4
) (
    input logic clk,
    input logic rst_n,
    horizontal_tf_gen_if.slave bus
);
`ifdef HTF_LANE_STRIDE_EN
    localparam bit LS = 1'b1;
`else
    localparam bit LS = 1'b0;
`endif
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [NCH-1:0][P_WIDTH-1:0] acc;
    logic [CNT_W-1:0] len, idx;
    logic [P_WIDTH-1:0] n, step;
    logic [IW-1:0] ini;
`ifdef HTF_LANE_STRIDE_EN
    logic [P_WIDTH-1:0] stride;
`endif
    // full double-width product so the reduction is exact for any modulus below 2^P_WIDTH
    function automatic logic [P_WIDTH-1:0] mulmod(input logic [P_WIDTH-1:0] a, b, m);
        return P_WIDTH'(({{P_WIDTH{1'b0}}, a} * {{P_WIDTH{1'b0}}, b}) % {{P_WIDTH{1'b0}}, m});
    endfunction
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = bus.start ? (LS && NCH > 1 ? INIT : RUN) : IDLE;
            INIT: state_nx = ini == IW'(NCH - 2) ? RUN : INIT;
            RUN:  state_nx = !bus.cen && idx == len ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus.busy     = state != IDLE;
        bus.tf_valid = state == RUN && !bus.cen;
        bus.done     = state == DONE;
    end
    assign bus.tf_out = acc;
    assign bus.tf_idx = idx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            idx  <= '0;
            len  <= '0;
            n    <= '0;
            step <= '0;
            ini  <= '0;
`ifdef HTF_LANE_STRIDE_EN
            stride <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    acc  <= bus.base_in;
                    len  <= bus.len_in;
                    n    <= bus.N_in;
                    step <= bus.step_in;
                    ini  <= '0;
`ifdef HTF_LANE_STRIDE_EN
                    stride <= bus.stride_in;
`endif
                end
`ifdef HTF_LANE_STRIDE_EN
                INIT: begin
                    acc[ini + 1'b1] <= mulmod(acc[ini], stride, n);
                    ini <= ini + 1'b1;
                end
`endif
                RUN: if (!bus.cen) begin
                    for (int c = 0; c < NCH; c++) acc[c] <= mulmod(acc[c], step, n);
                    idx <= idx == len ? '0 : idx + 1'b1;
                end
                default: idx <= '0;
            endcase
        end
    end
endmodule
